dm_sba_ctrl: RTL and testbench
==============================

# dm_sba_ctrl

System Bus Access (SBA) controller for the debug module. It turns debugger writes to the sbaddress/sbdata registers into single-beat transactions on the debug module's system-bus master port. It generates byte enables, aligns data lanes and handles read-on-address, read-on-data and auto-increment. It reports busy, busy-error and sberror status back to the DM register file, and owns the only path from the DMI to system memory.

## Interface
Parameters:
- BusWidth, 32, system bus data/address width; legal values 32 or 64

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- dmactive_i  in  1  DM active; low forces synchronous return to Idle and clears error state
- sbaddress_i  in  BusWidth  new sbaddress value from DMI write
- sbaddress_write_valid_i  in  1  one-cycle strobe, DMI wrote sbaddress
- sbdata_i  in  BusWidth  new sbdata value from DMI write
- sbdata_write_valid_i  in  1  one-cycle strobe, DMI wrote sbdata0
- sbdata_read_valid_i  in  1  one-cycle strobe, DMI read sbdata0
- sbreadonaddr_i, sbreadondata_i, sbautoincrement_i  in  1 each  sbcs control bits
- sbaccess_i  in  3  access size, log2 bytes
- sberror_clear_i  in  1  DMI write-1-to-clear of sberror
- sbbusyerror_clear_i  in  1  DMI write-1-to-clear of sbbusyerror
- sbaddress_o  out  BusWidth  current address register
- sbdata_o  out  BusWidth  last read data, zero-extended
- sbdata_valid_o  out  1  one-cycle strobe, sbdata_o updated
- sbbusy_o  out  1  state != Idle
- sbbusyerror_o  out  1  sticky busy error
- sberror_o  out  3  sticky error code: 0 none, 2 bad address, 3 misaligned, 4 unsupported size
- master_req_o  out  1  bus request
- master_add_o  out  BusWidth  bus address
- master_we_o  out  1  write enable
- master_wdata_o  out  BusWidth  lane-aligned write data
- master_be_o  out  BusWidth/8  byte enables
- master_gnt_i  in  1  request accepted
- master_r_valid_i  in  1  response valid
- master_r_err_i  in  1  response error
- master_r_rdata_i  in  BusWidth  read data

## Operation
- States use the DM's sba_state_e encoding: Idle, Read, Write, WaitRead, WaitWrite.
- Idle:
  - sbaddress write: load the address. If sbreadonaddr_i is set, go to Read.
  - sbdata write: go to Write.
  - sbdata read with sbreadondata_i set: go to Read.
- Read/Write:
  - Assert master_req_o, holding address, data, byte enables and write enable stable until master_gnt_i.
  - On grant, go to WaitRead/WaitWrite.
- WaitRead/WaitWrite:
  - On master_r_valid_i, return to Idle.
  - A read updates sbdata_o with rdata shifted right by 8·addr lane offset and masked to 2^sbaccess bytes, and pulses sbdata_valid_o.
- Auto-increment: on a successful response with sbautoincrement_i set, add 2^sbaccess_i to sbaddress_o, wrapping modulo 2^BusWidth.
- Byte enables: ((1<<2^sbaccess)-1) << addr[log2(BusWidth/8)-1:0]. Write data is replicated across all lanes.
- Pre-checks, evaluated in Idle before leaving it:
  - 2^sbaccess > BusWidth/8 sets sberror=4.
  - Address not aligned to 2^sbaccess sets sberror=3.
  - Either error means no bus request is issued and the state stays Idle.
- No new access starts while sberror_o != 0 or sbbusyerror_o = 1.
- A sbaddress/sbdata write, or a sbdata read, arriving while sbbusy_o=1 sets sbbusyerror_o and is otherwise ignored; the address register is not overwritten.
- Error clears take effect on the next clock. A clear and a set in the same cycle: set wins.

## Timing
- Reset values:
  - State Idle.
  - sbaddress_o=0, sbdata_o=0, sberror_o=0, sbbusyerror_o=0.
  - sbdata_valid_o=0, sbbusy_o=0, master_req_o=0, master_we_o=0.
  - master_add_o=0, master_wdata_o=0, master_be_o=0.
- The trigger strobe in cycle N produces master_req_o=1 in cycle N+1, registered.
- Minimum read latency is 3 cycles from strobe to sbdata_valid_o, given gnt in N+1 and r_valid in N+2. sbdata_valid_o is registered and lasts exactly one cycle.
- sbbusy_o rises in the cycle after the strobe and falls in the cycle after r_valid.
- r_valid arriving in the grant cycle is not accepted; the response is expected from the cycle after gnt.
- dmactive_i low mid-transaction: drop master_req_o next cycle, return to Idle, and ignore any late response.

## Configuration
- DM_SBA_BUSERR_EN:
  - Defined: master_r_err_i=1 with r_valid sets sberror=2. There is no sbdata update and no auto-increment.
  - Undefined: master_r_err_i is ignored and the response is treated as success.

## Test plan
- sbaccess=2, sbreadonaddr=1, write sbaddress=0x1000, gnt next cycle, rdata=0xDEADBEEF -> one request with add=0x1000 and be=4'hF; sbdata_o=0xDEADBEEF and sbdata_valid_o pulse in the 3rd cycle after the strobe.
- sbaccess=0, address 0x2003, sbdata write 0x5A -> be=4'b1000, wdata=0x5A5A5A5A; with autoincrement=1, sbaddress_o=0x2004 afterwards.
- sbaccess=2, address 0x1002, readonaddr=1 -> sberror_o=3, no master_req_o; sberror_clear_i then permits the next access.
- sbaccess=3 with BusWidth=32 -> sberror_o=4, no request.
- gnt withheld for 5 cycles, then a second sbdata write issued -> request signals held stable, sbbusyerror_o=1, exactly one bus write.
- With DM_SBA_BUSERR_EN defined, r_err=1 on a read at 0x3000 with autoincrement=1 -> sberror_o=2, sbaddress_o stays 0x3000, no sbdata_valid_o.

Source files
------------

// File: rtl/dm_sba_ctrl.sv
// rtl/dm_sba_ctrl.sv - debug module system bus access controller (single-beat master)
// Define DM_SBA_BUSERR_EN to report bus response errors as sberror=2.
module dm_sba_ctrl #(
    parameter int BusWidth = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  dmactive_i,
    input  logic [BusWidth-1:0]   sbaddress_i,
    input  logic                  sbaddress_write_valid_i,
    input  logic [BusWidth-1:0]   sbdata_i,
    input  logic                  sbdata_write_valid_i,
    input  logic                  sbdata_read_valid_i,
    input  logic                  sbreadonaddr_i,
    input  logic                  sbreadondata_i,
    input  logic                  sbautoincrement_i,
    input  logic [2:0]            sbaccess_i,
    input  logic                  sberror_clear_i,
    input  logic                  sbbusyerror_clear_i,
    output logic [BusWidth-1:0]   sbaddress_o,
    output logic [BusWidth-1:0]   sbdata_o,
    output logic                  sbdata_valid_o,
    output logic                  sbbusy_o,
    output logic                  sbbusyerror_o,
    output logic [2:0]            sberror_o,
    output logic                  master_req_o,
    output logic [BusWidth-1:0]   master_add_o,
    output logic                  master_we_o,
    output logic [BusWidth-1:0]   master_wdata_o,
    output logic [BusWidth/8-1:0] master_be_o,
    input  logic                  master_gnt_i,
    input  logic                  master_r_valid_i,
    input  logic                  master_r_err_i,
    input  logic [BusWidth-1:0]   master_r_rdata_i
);
    localparam int NumLanes = BusWidth / 8;
    localparam int OffW     = $clog2(NumLanes);

    typedef enum logic [2:0] {Idle, Read, Write, WaitRead, WaitWrite} sba_state_e;

    sba_state_e          state_q, state_d;
    logic [BusWidth-1:0] sbaddress_q, sbaddress_d;
    logic [BusWidth-1:0] sbdata_q, sbdata_d;
    logic                sbdata_valid_q, sbdata_valid_d;
    logic [2:0]          sberror_q, sberror_d;
    logic                sbbusyerror_q, sbbusyerror_d;
    logic [BusWidth-1:0] add_q, add_d;
    logic [BusWidth-1:0] wdata_q, wdata_d;
    logic [NumLanes-1:0] be_q, be_d;
    logic                we_q, we_d;
    logic [2:0]          access_q, access_d;

    logic [BusWidth-1:0] tgt_addr, wdata_rep, rdata_lane, rdata_ext;
    logic [NumLanes-1:0] be_new;
    logic                start_rd, start_wr, any_strobe, size_err, align_err, resp_err;
    int                  new_off, new_bytes, rsp_bytes;

`ifdef DM_SBA_BUSERR_EN
    assign resp_err = master_r_err_i;
`else
    logic unused_r_err;
    assign unused_r_err = master_r_err_i;
    assign resp_err     = 1'b0;
`endif

    // Launch-side decode uses the freshly written address when the trigger is an sbaddress write.
    always_comb begin
        tgt_addr   = sbaddress_write_valid_i ? sbaddress_i : sbaddress_q;
        start_rd   = (sbaddress_write_valid_i && sbreadonaddr_i) ||
                     (sbdata_read_valid_i && sbreadondata_i);
        start_wr   = sbdata_write_valid_i;
        any_strobe = sbaddress_write_valid_i | sbdata_write_valid_i | sbdata_read_valid_i;
        new_off    = int'(tgt_addr[OffW-1:0]);
        new_bytes  = 1 << sbaccess_i;
        size_err   = int'(sbaccess_i) > OffW;
        align_err  = 1'b0;
        be_new     = '0;
        wdata_rep  = '0;
        for (int i = 0; i < OffW; i++) begin
            if (i < int'(sbaccess_i) && tgt_addr[i]) align_err = 1'b1;
        end
        for (int i = 0; i < NumLanes; i++) begin
            be_new[i]           = (i >= new_off) && (i < new_off + new_bytes);
            wdata_rep[8*i +: 8] = sbdata_i[8*(i % new_bytes) +: 8];
        end
        rsp_bytes  = 1 << access_q;
        rdata_lane = master_r_rdata_i >> {add_q[OffW-1:0], 3'b000};
        rdata_ext  = '0;
        for (int i = 0; i < NumLanes; i++) begin
            rdata_ext[8*i +: 8] = (i < rsp_bytes) ? rdata_lane[8*i +: 8] : 8'h00;
        end
    end

    always_comb begin
        state_d        = state_q;
        sbaddress_d    = sbaddress_q;
        sbdata_d       = sbdata_q;
        sbdata_valid_d = 1'b0;
        sberror_d      = sberror_q;
        sbbusyerror_d  = sbbusyerror_q;
        add_d          = add_q;
        wdata_d        = wdata_q;
        be_d           = be_q;
        we_d           = we_q;
        access_d       = access_q;

        if (sberror_clear_i)     sberror_d     = '0;
        if (sbbusyerror_clear_i) sbbusyerror_d = 1'b0;

        case (state_q)
            Idle: begin
                if (sbaddress_write_valid_i) sbaddress_d = sbaddress_i;
                if ((start_rd || start_wr) && sberror_q == 3'd0 && !sbbusyerror_q) begin
                    if (size_err) begin
                        sberror_d = 3'd4;
                    end else if (align_err) begin
                        sberror_d = 3'd3;
                    end else begin
                        state_d  = start_wr ? Write : Read;
                        add_d    = tgt_addr;
                        we_d     = start_wr;
                        be_d     = be_new;
                        access_d = sbaccess_i;
                        if (start_wr) wdata_d = wdata_rep;
                    end
                end
            end
            Read:  if (master_gnt_i) state_d = WaitRead;
            Write: if (master_gnt_i) state_d = WaitWrite;
            WaitRead, WaitWrite: begin
                if (master_r_valid_i) begin
                    state_d = Idle;
                    if (resp_err) begin
                        sberror_d = 3'd2;
                    end else begin
                        if (sbautoincrement_i)
                            sbaddress_d = sbaddress_q + (BusWidth'(1) << access_q);
                        if (state_q == WaitRead) begin
                            sbdata_d       = rdata_ext;
                            sbdata_valid_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = Idle;
        endcase

        if (state_q != Idle && any_strobe) sbbusyerror_d = 1'b1;

        // Deactivation abandons any transfer in flight; a late response must not land.
        if (!dmactive_i) begin
            state_d        = Idle;
            sberror_d      = '0;
            sbbusyerror_d  = 1'b0;
            sbdata_valid_d = 1'b0;
            sbaddress_d    = sbaddress_q;
            sbdata_d       = sbdata_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= Idle;
            sbaddress_q    <= '0;
            sbdata_q       <= '0;
            sbdata_valid_q <= 1'b0;
            sberror_q      <= '0;
            sbbusyerror_q  <= 1'b0;
            add_q          <= '0;
            wdata_q        <= '0;
            be_q           <= '0;
            we_q           <= 1'b0;
            access_q       <= '0;
        end else begin
            state_q        <= state_d;
            sbaddress_q    <= sbaddress_d;
            sbdata_q       <= sbdata_d;
            sbdata_valid_q <= sbdata_valid_d;
            sberror_q      <= sberror_d;
            sbbusyerror_q  <= sbbusyerror_d;
            add_q          <= add_d;
            wdata_q        <= wdata_d;
            be_q           <= be_d;
            we_q           <= we_d;
            access_q       <= access_d;
        end
    end

    assign sbaddress_o    = sbaddress_q;
    assign sbdata_o       = sbdata_q;
    assign sbdata_valid_o = sbdata_valid_q;
    assign sbbusy_o       = (state_q != Idle);
    assign sbbusyerror_o  = sbbusyerror_q;
    assign sberror_o      = sberror_q;
    assign master_req_o   = (state_q == Read) || (state_q == Write);
    assign master_add_o   = add_q;
    assign master_we_o    = we_q;
    assign master_wdata_o = wdata_q;
    assign master_be_o    = be_q;

endmodule

// File: tb/tb_dm_sba_ctrl.sv
// tb/tb_dm_sba_ctrl.sv - directed self-checking bench for dm_sba_ctrl
module tb_dm_sba_ctrl;
    localparam int BW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          dmactive;
    logic [BW-1:0] sbaddress_i, sbdata_i, rdata;
    logic          addr_wv, data_wv, data_rv;
    logic          readonaddr, readondata, autoinc;
    logic [2:0]    sbaccess;
    logic          err_clr, berr_clr;
    logic [BW-1:0] sbaddress_o, sbdata_o, m_add, m_wdata;
    logic          sbdata_valid, sbbusy, sbbusyerror;
    logic [2:0]    sberror;
    logic          m_req, m_we, gnt, r_valid, r_err;
    logic [BW/8-1:0] m_be;

    int n_cmp = 0;
    int n_bad = 0;
    int n_gnt = 0;
    int g0;
    logic [BW-1:0] exp_data;

    dm_sba_ctrl #(.BusWidth(BW)) dut (
        .clk_i(clk), .rst_i(rst), .dmactive_i(dmactive),
        .sbaddress_i(sbaddress_i), .sbaddress_write_valid_i(addr_wv),
        .sbdata_i(sbdata_i), .sbdata_write_valid_i(data_wv), .sbdata_read_valid_i(data_rv),
        .sbreadonaddr_i(readonaddr), .sbreadondata_i(readondata), .sbautoincrement_i(autoinc),
        .sbaccess_i(sbaccess), .sberror_clear_i(err_clr), .sbbusyerror_clear_i(berr_clr),
        .sbaddress_o(sbaddress_o), .sbdata_o(sbdata_o), .sbdata_valid_o(sbdata_valid),
        .sbbusy_o(sbbusy), .sbbusyerror_o(sbbusyerror), .sberror_o(sberror),
        .master_req_o(m_req), .master_add_o(m_add), .master_we_o(m_we),
        .master_wdata_o(m_wdata), .master_be_o(m_be),
        .master_gnt_i(gnt), .master_r_valid_i(r_valid), .master_r_err_i(r_err),
        .master_r_rdata_i(rdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (m_req && gnt) n_gnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; dmactive = 1'b1;
        sbaddress_i = '0; sbdata_i = '0; rdata = '0;
        addr_wv = 0; data_wv = 0; data_rv = 0;
        readonaddr = 0; readondata = 0; autoinc = 0; sbaccess = 3'd2;
        err_clr = 0; berr_clr = 0; gnt = 0; r_valid = 0; r_err = 0;
        #2;
        chk("rst_addr", sbaddress_o, 0);
        chk("rst_data", sbdata_o, 0);
        chk("rst_flags", {sbdata_valid, sbbusy, sbbusyerror, sberror, m_req, m_we}, 0);
        chk("rst_bus", {m_add, m_wdata, m_be}, 0);
        step(); step();
        rst = 1'b0;
        step();

        // word read on address write, minimum latency
        sbaccess = 3'd2; readonaddr = 1; sbaddress_i = 32'h1000; addr_wv = 1;
        step(); addr_wv = 0;
        chk("rd_req", {m_req, m_we, sbbusy, sbdata_valid}, 4'b1010);
        chk("rd_add", m_add, 32'h1000);
        chk("rd_be", m_be, 4'hF);
        gnt = 1;
        step(); gnt = 0;
        chk("rd_wait", {m_req, sbbusy, sbdata_valid}, 3'b010);
        r_valid = 1; rdata = 32'hDEADBEEF;
        step(); r_valid = 0;
        chk("rd_valid", {sbdata_valid, sbbusy}, 2'b10);
        chk("rd_data", sbdata_o, 32'hDEADBEEF);
        step();
        chk("rd_valid_drop", sbdata_valid, 0);
        readonaddr = 0;

        // byte write at lane 3 with auto-increment
        sbaccess = 3'd0; sbaddress_i = 32'h2003; addr_wv = 1;
        step(); addr_wv = 0;
        chk("wb_noreq", {m_req, sbbusy}, 2'b00);
        autoinc = 1; sbdata_i = 32'h5A; data_wv = 1;
        step(); data_wv = 0;
        chk("wb_req", {m_req, m_we}, 2'b11);
        chk("wb_add", m_add, 32'h2003);
        chk("wb_be", m_be, 4'b1000);
        chk("wb_wdata", m_wdata, 32'h5A5A5A5A);
        gnt = 1; step(); gnt = 0;
        r_valid = 1; step(); r_valid = 0;
        chk("wb_done", {sbbusy, sbdata_valid}, 2'b00);
        chk("wb_autoinc", sbaddress_o, 32'h2004);
        autoinc = 0;

        // misaligned word read, blocked retry, clear, then legal read
        sbaccess = 3'd2; readonaddr = 1; sbaddress_i = 32'h1002; addr_wv = 1;
        step(); addr_wv = 0;
        chk("mis_err", sberror, 3'd3);
        chk("mis_noreq", {m_req, sbbusy}, 2'b00);
        chk("mis_addr", sbaddress_o, 32'h1002);
        sbdata_i = 32'h1; data_wv = 1;
        step(); data_wv = 0;
        chk("mis_blocked", {m_req, sbbusy}, 2'b00);
        err_clr = 1; step(); err_clr = 0;
        chk("mis_clear", sberror, 0);
        sbaddress_i = 32'h1004; addr_wv = 1;
        step(); addr_wv = 0;
        chk("mis_next_req", {m_req, m_add}, {1'b1, 32'h1004});
        gnt = 1; step(); gnt = 0;
        r_valid = 1; rdata = 32'h12345678; step(); r_valid = 0;
        chk("mis_next_data", {sbdata_valid, sbdata_o}, {1'b1, 32'h12345678});
        readonaddr = 0;

        // unsupported size on a 32-bit bus
        sbaccess = 3'd3; data_wv = 1;
        step(); data_wv = 0;
        chk("size_err", sberror, 3'd4);
        chk("size_noreq", {m_req, sbbusy}, 2'b00);
        err_clr = 1; step(); err_clr = 0;

        // grant withheld, second writes collide with busy
        sbaccess = 3'd2; sbaddress_i = 32'h4000; addr_wv = 1;
        step(); addr_wv = 0;
        sbdata_i = 32'hCAFEF00D; data_wv = 1; g0 = n_gnt;
        step(); data_wv = 0;
        for (int k = 0; k < 5; k++) begin
            chk("hold_sig", {m_req, m_we, m_be, m_add, m_wdata},
                {1'b1, 1'b1, 4'hF, 32'h4000, 32'hCAFEF00D});
            if (k == 1) begin
                sbdata_i = 32'h11111111; data_wv = 1;
                sbaddress_i = 32'h5000; addr_wv = 1;
            end else begin
                data_wv = 0; addr_wv = 0;
            end
            step();
        end
        chk("busyerr_set", sbbusyerror, 1);
        chk("busyerr_addr", sbaddress_o, 32'h4000);
        gnt = 1; step(); gnt = 0;
        r_valid = 1; step(); r_valid = 0;
        step(); step();
        chk("one_write", n_gnt - g0, 1);
        chk("busyerr_idle", {m_req, sbbusy, sbbusyerror}, 3'b001);
        berr_clr = 1; step(); berr_clr = 0;
        chk("busyerr_clr", sbbusyerror, 0);

        // halfword read in upper lanes
        sbaccess = 3'd1; readonaddr = 1; sbaddress_i = 32'h6002; addr_wv = 1;
        step(); addr_wv = 0;
        chk("hw_be", {m_req, m_be}, {1'b1, 4'b1100});
        gnt = 1; step(); gnt = 0;
        r_valid = 1; rdata = 32'hABCD1234; step(); r_valid = 0;
        chk("hw_data", {sbdata_valid, sbdata_o}, {1'b1, 32'h0000ABCD});

        // read with bus error response
        sbaccess = 3'd2; autoinc = 1; sbaddress_i = 32'h3000; addr_wv = 1;
        step(); addr_wv = 0;
        gnt = 1; step(); gnt = 0;
        r_valid = 1; r_err = 1; rdata = 32'h0BADF00D; step(); r_valid = 0; r_err = 0;
`ifdef DM_SBA_BUSERR_EN
        chk("berr_code", sberror, 3'd2);
        chk("berr_addr", sbaddress_o, 32'h3000);
        chk("berr_nodata", {sbdata_valid, sbdata_o}, {1'b0, 32'h0000ABCD});
        exp_data = 32'h0000ABCD;
`else
        chk("rerr_ign_code", sberror, 3'd0);
        chk("rerr_ign_addr", sbaddress_o, 32'h3004);
        chk("rerr_ign_data", {sbdata_valid, sbdata_o}, {1'b1, 32'h0BADF00D});
        exp_data = 32'h0BADF00D;
`endif
        autoinc = 0;
        err_clr = 1; step(); err_clr = 0;

        // deactivation mid-read, late response ignored
        sbaddress_i = 32'h7000; addr_wv = 1;
        step(); addr_wv = 0;
        chk("dm_req", m_req, 1);
        dmactive = 0;
        step(); dmactive = 1;
        chk("dm_drop", {m_req, sbbusy}, 2'b00);
        r_valid = 1; rdata = 32'hFFFFFFFF; step(); r_valid = 0;
        chk("dm_late", {sbdata_valid, sbdata_o}, {1'b0, exp_data});
        readonaddr = 0;

        // read triggered by sbdata read
        readondata = 1; data_rv = 1;
        step(); data_rv = 0;
        chk("rod_req", {m_req, m_we, m_add}, {2'b10, 32'h7000});
        gnt = 1; step(); gnt = 0;
        r_valid = 1; rdata = 32'h55AA55AA; step(); r_valid = 0;
        chk("rod_data", {sbdata_valid, sbdata_o}, {1'b1, 32'h55AA55AA});
        readondata = 0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
